// File: rtl/cmd_pulse_decoder.sv
// Byte-command decoder: pops one byte per three cycles from an FWFT FIFO and
// fires one-shot pulses or toggles a level on the channel whose code matches.
module cmd_pulse_decoder #(
    parameter int                CLK_HZ      = 100_000_000,
    parameter int                DIV         = 2000,
    parameter int                NUM_CH      = 4,
    parameter logic [7:0]        CMD_BASE    = 8'h30,
    parameter logic [NUM_CH-1:0] TOGGLE_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rd_en,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [7:0]        last_cmd,
    output logic              unknown_cmd,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    localparam int P_CYCLE = CLK_HZ / DIV;
    localparam int CW      = $clog2(P_CYCLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(P_CYCLE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_POP    = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    // Handshake: rx_data is valid whenever rx_empty=0; the byte is taken on
    // the IDLE->POP edge and rd_en (high only in POP) acknowledges it.

    logic [1:0]        state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [7:0]        last_q, last_d;
    logic              unknown_q, unknown_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic              capture;
    logic [NUM_CH-1:0] hit;

    function automatic logic [7:0] ch_code(input int idx);
        logic [7:0] off;
        off = 8'(idx);
        return 8'(CMD_BASE + off);
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!rx_empty) state_d = ST_POP;
            ST_POP:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign capture = (state_q == ST_IDLE) && !rx_empty;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = capture && (rx_data == ch_code(i));
        end
    end

    // A match always wins over expiry, so a retrigger never dips low.
    always_comb begin
        pulse_d = pulse_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (TOGGLE_MASK[i]) begin
                cnt_d[i] = '0;
                if (hit[i]) pulse_d[i] = ~pulse_q[i];
            end else if (hit[i]) begin
                pulse_d[i] = 1'b1;
                cnt_d[i]   = '0;
            end else if (pulse_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    pulse_d[i] = 1'b0;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rd_en_d   = (state_d == ST_POP);
        last_d    = (|hit) ? rx_data : last_q;
        unknown_d = capture && !(|hit);
        busy_d    = |(pulse_d & ~TOGGLE_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            pulse_q   <= '0;
            last_q    <= 8'h00;
            unknown_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            pulse_q   <= pulse_d;
            last_q    <= last_d;
            unknown_q <= unknown_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rd_en       = rd_en_q;
    assign pulse_out   = pulse_q;
    assign last_cmd    = last_q;
    assign unknown_cmd = unknown_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule
